pipeline_hazard_ctrl: RTL and testbench

//  Next-generation hazard controller for the 5-stage LEGv8 pipeline; drives stall/flush enables for the pipeline registers.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 hazard controller: FSM states and the
// pipeline-register control vector with its canned encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Field order: PC, IF/ID, ID/EX, EX/MEM writes, then IF/ID..MEM/WB flushes
    localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b1111_0000);
    localparam ctrl_t CTRL_MEM_WAIT = ctrl_t'(8'b0000_0001);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1110);
    localparam ctrl_t CTRL_LU_STALL = ctrl_t'(8'b0011_0100);

    function automatic logic [3:0] lu_init(input int stalls);
        return 4'(stalls - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage LEGv8 pipeline: load-use stall,
// taken-branch flush and data-memory freeze, plus stall/freeze counters.
//
// state      | meaning
// S_RUN      | normal flow; a load-use hazard stalls this cycle
// S_LU_STALL | extra load-use bubbles, lu_left counts them down
// S_MEM_WAIT | pipeline frozen on dmem; saved_state resumes afterwards
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W           = 5,
    parameter int ZERO_REG        = 31,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_E,
    input  logic [REG_W-1:0] Rd_E,
    input  logic [REG_W-1:0] Rs1_D,
    input  logic [REG_W-1:0] Rs2_D,
    input  logic             Rs1_used_D,
    input  logic             Rs2_used_D,
    input  logic             Branch_taken_M,
    input  logic             MemAccess_M,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam logic [3:0] LU_INIT = lu_init(LOAD_USE_STALLS);

    state_t     state;
    state_t     saved_state;
    state_t     eff_state;
    logic [3:0] lu_left;
    logic       hz;
    logic       memwait;
    logic       lu_active;
    logic       lu_inc;
    logic       mw_inc;
    ctrl_t      ctrl;

    assign hz = MemRead_E && (Rd_E != REG_W'(ZERO_REG)) &&
                ((Rs1_used_D && (Rd_E == Rs1_D)) || (Rs2_used_D && (Rd_E == Rs2_D)));
    assign memwait = MemAccess_M && !dmem_ready;

    // Once dmem is ready the frozen state behaves exactly as the one it interrupted
    assign eff_state = (state == S_MEM_WAIT) ? saved_state : state;
    assign lu_active = (eff_state == S_LU_STALL) || ((eff_state == S_RUN) && hz);

    always_comb begin
        ctrl = CTRL_RUN;
        if (!reset) begin
            ctrl = CTRL_RUN;
        end else if (memwait) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (Branch_taken_M) begin
            ctrl = CTRL_BRANCH;
        end else if (lu_active) begin
            ctrl = CTRL_LU_STALL;
        end
    end

    assign lu_inc = reset && !memwait && !Branch_taken_M && lu_active;
    assign mw_inc = reset && memwait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RUN;
            saved_state <= S_RUN;
            lu_left     <= '0;
        end else if (memwait) begin
            state <= S_MEM_WAIT;
            if (state != S_MEM_WAIT) begin
                saved_state <= state;
            end
        end else if (Branch_taken_M) begin
            state       <= S_RUN;
            saved_state <= S_RUN;
            lu_left     <= '0;
        end else if (eff_state == S_LU_STALL) begin
            lu_left <= lu_left - 4'd1;
            state   <= (lu_left == 4'd1) ? S_RUN : S_LU_STALL;
        end else if ((eff_state == S_RUN) && hz && (LOAD_USE_STALLS > 1)) begin
            state   <= S_LU_STALL;
            lu_left <= LU_INIT;
        end else begin
            state <= eff_state;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign ID_EX_Write  = ctrl.id_ex_write;
    assign EX_MEM_Write = ctrl.ex_mem_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign EX_MEM_Flush = ctrl.ex_mem_flush;
    assign MEM_WB_Flush = ctrl.mem_wb_flush;

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_inc),
        .count (lu_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mw_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mw_inc),
        .count (mem_wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one single-bubble unit with 3-bit counters and one
// three-bubble unit with 32-bit counters, driven by the same inputs.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] E_RUN = 8'hF0;
    localparam logic [7:0] E_LU  = 8'h34;
    localparam logic [7:0] E_BR  = 8'hFE;
    localparam logic [7:0] E_MW  = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       MemRead_E, Rs1_used_D, Rs2_used_D, Branch_taken_M, MemAccess_M, dmem_ready;
    logic [4:0] Rd_E, Rs1_D, Rs2_D;

    logic        pc1, ifw1, idw1, exw1, iff1, idf1, exf1, wbf1;
    logic        pc3, ifw3, idw3, exw3, iff3, idf3, exf3, wbf3;
    logic [2:0]  lu1, mw1;
    logic [31:0] lu3, mw3;
    logic [7:0]  v1, v3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign v1 = {pc1, ifw1, idw1, exw1, iff1, idf1, exf1, wbf1};
    assign v3 = {pc3, ifw3, idw3, exw3, iff3, idf3, exf3, wbf3};

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_used_D(Rs1_used_D), .Rs2_used_D(Rs2_used_D),
        .Branch_taken_M(Branch_taken_M), .MemAccess_M(MemAccess_M), .dmem_ready(dmem_ready),
        .PCWrite(pc1), .IF_ID_Write(ifw1), .ID_EX_Write(idw1), .EX_MEM_Write(exw1),
        .IF_ID_Flush(iff1), .ID_EX_Flush(idf1), .EX_MEM_Flush(exf1), .MEM_WB_Flush(wbf1),
        .lu_stall_cnt(lu1), .mem_wait_cnt(mw1)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(32)) dut3 (
        .clk(clk), .reset(reset), .MemRead_E(MemRead_E), .Rd_E(Rd_E),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_used_D(Rs1_used_D), .Rs2_used_D(Rs2_used_D),
        .Branch_taken_M(Branch_taken_M), .MemAccess_M(MemAccess_M), .dmem_ready(dmem_ready),
        .PCWrite(pc3), .IF_ID_Write(ifw3), .ID_EX_Write(idw3), .EX_MEM_Write(exw3),
        .IF_ID_Flush(iff3), .ID_EX_Flush(idf3), .EX_MEM_Flush(exf3), .MEM_WB_Flush(wbf3),
        .lu_stall_cnt(lu3), .mem_wait_cnt(mw3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic br, input logic ma, input logic rdy);
        MemRead_E = mr; Rd_E = rd; Rs1_D = rs1; Rs2_D = rs2;
        Rs1_used_D = u1; Rs2_used_D = u2;
        Branch_taken_M = br; MemAccess_M = ma; dmem_ready = rdy;
    endtask

    task automatic clr();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    endtask

    // Inputs are already applied just after a rising edge; check, then advance one cycle
    task automatic cyc(input string tag, input logic [7:0] e1, input logic [7:0] e3);
        #1;
        chk({tag, "/u1"}, 32'(v1), 32'(e1));
        chk({tag, "/u3"}, 32'(v3), 32'(e3));
        @(posedge clk);
        #1;
    endtask

    task automatic cnts(input string tag, input int l1, input int m1, input int l3, input int m3);
        chk({tag, "/lu1"}, 32'(lu1), 32'(l1));
        chk({tag, "/mw1"}, 32'(mw1), 32'(m1));
        chk({tag, "/lu3"}, lu3, 32'(l3));
        chk({tag, "/mw3"}, mw3, 32'(m3));
    endtask

    initial begin
        // reset held: hazard on inputs must not reach the outputs
        set_in(1, 5'd1, 5'd1, 5'd0, 1, 0, 0, 0, 1);
        #3;
        chk("rst_out/u1", 32'(v1), 32'(E_RUN));
        chk("rst_out/u3", 32'(v3), 32'(E_RUN));
        cnts("rst", 0, 0, 0, 0);
        clr();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single load-use hazard on Rs1: 1 bubble vs 3 bubbles
        set_in(1, 5'd1, 5'd1, 5'd0, 1, 0, 0, 0, 1);
        cyc("lu_first", E_LU, E_LU);
        clr();
        cyc("lu_second", E_RUN, E_LU);
        cyc("lu_third", E_RUN, E_LU);
        cyc("lu_done", E_RUN, E_RUN);
        cnts("lu", 1, 0, 3, 0);

        // non-hazards: XZR destination, unused Rs2, non-load
        set_in(1, 5'd31, 5'd31, 5'd31, 1, 1, 0, 0, 1);
        cyc("xzr", E_RUN, E_RUN);
        set_in(1, 5'd4, 5'd0, 5'd4, 1, 0, 0, 0, 1);
        cyc("rs2_unused", E_RUN, E_RUN);
        set_in(0, 5'd4, 5'd4, 5'd4, 1, 1, 0, 0, 1);
        cyc("no_load", E_RUN, E_RUN);
        cnts("nohz", 1, 0, 3, 0);

        // Rs2 hazard, then taken branch in the 2nd stall cycle
        set_in(1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 0, 1);
        cyc("rs2_hz", E_LU, E_LU);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        cyc("br_in_stall", E_BR, E_BR);
        clr();
        cyc("br_after", E_RUN, E_RUN);
        cnts("br", 2, 0, 4, 0);

        // 4-cycle dmem freeze with a taken branch waiting behind it
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc("freeze", E_MW, E_MW);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
        cyc("freeze_br", E_BR, E_BR);
        clr();
        cyc("freeze_after", E_RUN, E_RUN);
        cnts("freeze", 2, 4, 4, 4);

        // freeze during a multi-bubble stall resumes the remaining bubbles
        set_in(1, 5'd2, 5'd2, 5'd0, 1, 0, 0, 0, 1);
        cyc("lumw_hz", E_LU, E_LU);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        cyc("lumw_f1", E_MW, E_MW);
        cyc("lumw_f2", E_MW, E_MW);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
        cyc("lumw_res2", E_RUN, E_LU);
        clr();
        cyc("lumw_res3", E_RUN, E_LU);
        cyc("lumw_done", E_RUN, E_RUN);
        cnts("lumw", 3, 6, 7, 6);

        // 3-bit counter saturates at 7
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("sat", E_MW, E_MW);
        clr();
        cyc("sat_after", E_RUN, E_RUN);
        cnts("sat", 3, 7, 7, 9);

        // async reset in the 2nd stall cycle
        set_in(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 1);
        cyc("rst_hz", E_LU, E_LU);
        clr();
        #1;
        chk("rst_pre/u3", 32'(v3), 32'(E_LU));
        reset = 1'b0;
        #1;
        chk("rst_mid/u1", 32'(v1), 32'(E_RUN));
        chk("rst_mid/u3", 32'(v3), 32'(E_RUN));
        cnts("rst_mid", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_rel1", E_RUN, E_RUN);
        cyc("rst_rel2", E_RUN, E_RUN);
        cnts("rst_rel", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
